// File: rtl/stream_debug_pkg.sv
// Shared definitions for the debug stream capture/playback pair.
// Byte ordering within a word is defined here so both ends agree.
package stream_debug_pkg;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FULL = 2'd1,
    ST_PLAY = 2'd2
  } player_state_e;

  function automatic int BYTES_PER_WORD(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/stream_player_ram.sv
// Simple dual-port sample memory: one write port, one registered read port.
// The read register holds its value whenever re_i is low.
module stream_player_ram #(
  parameter int DAT_WIDTH = 72,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DAT_WIDTH-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DAT_WIDTH-1:0] rdata_o
);

  logic [DAT_WIDTH-1:0] mem_q [2**ADDR_BITS];
  logic [DAT_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_player.sv
// Loads a sample memory byte-by-byte from the debug link, then replays it
// as full-width words on a valid/ready stream.
module stream_player
  import stream_debug_pkg::*;
#(
  parameter int DAT_WIDTH = 72,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [7:0]           byte_in,
  input  logic                 byte_in_valid,
  output logic                 byte_in_ready,
  input  logic                 start_playback,
  output logic                 loaded,
  output logic                 playing,
  output logic [DAT_WIDTH-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  localparam int BYTES = BYTES_PER_WORD(DAT_WIDTH);
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'((2**ADDR_BITS) - 1);
  localparam logic [CNT_W-1:0]     LAST_BYTE = CNT_W'(BYTES - 1);

  player_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DAT_WIDTH-1:0]   asm_q, asm_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_BITS-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_BITS-1:0]   out_idx_q, out_idx_d;
  logic                   rd_done_q, rd_done_d;
  logic                   ram_vld_q, ram_vld_d;
  logic                   out_vld_q, out_vld_d;
  logic [DAT_WIDTH-1:0]   out_q, out_d;

  logic                   byte_acc, word_done, ram_re, ram_move, out_hs;
  logic [DAT_WIDTH+7:0]   asm_cat;
  logic [DAT_WIDTH-1:0]   asm_next, ram_rdata;

  // New byte enters at the top and shifts down, so the first byte of a word
  // ends up in bits [7:0] once all BYTES have arrived.
  assign asm_cat  = {byte_in, asm_q};
  assign asm_next = asm_cat[DAT_WIDTH+7:8];

  assign byte_acc  = byte_in_valid && (state_q == ST_LOAD);
  assign word_done = byte_acc && (cnt_q == LAST_BYTE);
  assign out_hs    = out_vld_q && data_out_ready;
  assign ram_move  = ram_vld_q && (!out_vld_q || out_hs);
  assign ram_re    = (state_q == ST_PLAY) && !rd_done_q && (!ram_vld_q || ram_move);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    out_idx_d = out_idx_q;
    rd_done_d = rd_done_q;
    ram_vld_d = ram_vld_q;
    out_vld_d = out_vld_q;
    out_d     = out_q;
    unique case (state_q)
      ST_LOAD: begin
        if (byte_acc) begin
          asm_d = asm_next;
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (word_done) begin
          cnt_d = '0;
          if (wr_addr_q == LAST_ADDR) begin
            state_d   = ST_FULL;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_BITS'(1);
          end
        end
      end
      ST_FULL: begin
        if (start_playback) begin
          state_d   = ST_PLAY;
          rd_addr_d = '0;
          rd_done_d = 1'b0;
          out_idx_d = '0;
        end
      end
      ST_PLAY: begin
        if (ram_re) begin
          if (rd_addr_q == LAST_ADDR) rd_done_d = 1'b1;
          else                        rd_addr_d = rd_addr_q + ADDR_BITS'(1);
        end
        if (ram_re)        ram_vld_d = 1'b1;
        else if (ram_move) ram_vld_d = 1'b0;
        if (ram_move) begin
          out_d     = ram_rdata;
          out_vld_d = 1'b1;
        end else if (out_hs) begin
          out_vld_d = 1'b0;
        end
        if (out_hs) begin
          if (out_idx_q == LAST_ADDR) begin
            state_d   = ST_LOAD;
            rd_addr_d = '0;
            wr_addr_d = '0;
            cnt_d     = '0;
            rd_done_d = 1'b0;
            ram_vld_d = 1'b0;
            out_vld_d = 1'b0;
            out_idx_d = '0;
          end else begin
            out_idx_d = out_idx_q + ADDR_BITS'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      asm_q     <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      out_idx_q <= '0;
      rd_done_q <= 1'b0;
      ram_vld_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      out_idx_q <= out_idx_d;
      rd_done_q <= rd_done_d;
      ram_vld_q <= ram_vld_d;
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
    end
  end

  stream_player_ram #(
    .DAT_WIDTH(DAT_WIDTH),
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk    (clk),
    .we_i   (word_done),
    .waddr_i(wr_addr_q),
    .wdata_i(asm_next),
    .re_i   (ram_re),
    .raddr_i(rd_addr_q),
    .rdata_o(ram_rdata)
  );

  assign byte_in_ready  = (state_q == ST_LOAD);
  assign loaded         = (state_q == ST_FULL);
  assign playing        = (state_q == ST_PLAY);
  assign data_out       = out_q;
  assign data_out_valid = out_vld_q;

endmodule

// File: tb/tb_stream_player.sv
// Scoreboard bench for stream_player: a byte-level model builds the expected
// memory image, and a monitor checks every replayed word against it.
module tb_stream_player;

  localparam int W     = 72;
  localparam int NB    = W / 8;
  localparam int DEPTH = 16;
  localparam int NBYTE = NB * DEPTH;

  logic          clk = 1'b0;
  logic          arst;
  logic [7:0]    byte_in;
  logic          byte_in_valid;
  logic          byte_in_ready;
  logic          start_playback;
  logic          loaded;
  logic          playing;
  logic [W-1:0]  data_out;
  logic          data_out_valid;
  logic          data_out_ready;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            ready_mode = 0;
  logic [W-1:0]  exp_mem [DEPTH];
  logic [W-1:0]  exp_q [$];
  int            hs_count, first_hs, last_hs;
  logic [W-1:0]  first_word, last_word;
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_data;

  stream_player dut (
    .clk           (clk),
    .arst          (arst),
    .byte_in       (byte_in),
    .byte_in_valid (byte_in_valid),
    .byte_in_ready (byte_in_ready),
    .start_playback(start_playback),
    .loaded        (loaded),
    .playing       (playing),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       data_out_ready = 1'b1;
      1:       data_out_ready = 1'($urandom % 2);
      default: data_out_ready = 1'b0;
    endcase
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every handshake pops one expected word; stalled words must hold.
  always @(negedge clk) begin
    if (arst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (!data_out_valid || data_out !== prev_data) begin
          bad++;
          $display("FAIL stall_hold: got v=%b %h expected v=1 %h", data_out_valid, data_out, prev_data);
        end
      end
      if (data_out_valid && data_out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got %h expected no output", data_out);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (data_out !== e) begin
            bad++;
            $display("FAIL word_%0d: got %h expected %h", hs_count, data_out, e);
          end
        end
        if (hs_count == 0) begin
          first_hs   = cyc;
          first_word = data_out;
        end
        last_hs   = cyc;
        last_word = data_out;
        hs_count++;
      end
      prev_stall = data_out_valid && !data_out_ready;
      prev_data  = data_out;
    end
  end

  task automatic wait_accept(input int i);
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (i == NBYTE - 1 && n == 0) chk1("loaded_before_last", loaded, 1'b0);
      ok = byte_in_ready;
      @(posedge clk); #1;
    end
    if (!ok) chk1("byte_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic load_all(input bit gaps, input bit rand_data, input int pulse_at);
    logic [7:0] b;
    for (int i = 0; i < NBYTE; i++) begin
      b = rand_data ? 8'($urandom) : 8'(i);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        byte_in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == pulse_at) start_playback = 1'b1;
      byte_in       = b;
      byte_in_valid = 1'b1;
      wait_accept(i);
      if (i == pulse_at) begin
        start_playback = 1'b0;
        chk1("early_start_ignored", playing, 1'b0);
      end
      exp_mem[i / NB][8*(i % NB) +: 8] = b;
    end
    // Producer keeps offering a byte; it must not be consumed while full.
    byte_in = 8'hA5;
    chk1("loaded_after_last", loaded, 1'b1);
    chk1("ready_low_when_full", byte_in_ready, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk1("ready_stays_low", byte_in_ready, 1'b0);
    end
    @(posedge clk); #1;
    byte_in_valid = 1'b0;
  endtask

  task automatic play(input int mode);
    bit done = 1'b0;
    ready_mode = mode;
    hs_count   = 0;
    for (int w = 0; w < DEPTH; w++) exp_q.push_back(exp_mem[w]);
    @(posedge clk); #1;
    start_playback = 1'b1;
    @(posedge clk); #1;
    start_playback = 1'b0;
    if (mode == 0) begin
      @(negedge clk); chk1("valid_after_n", data_out_valid, 1'b0);
      @(negedge clk); chk1("playing_after_n1", playing, 1'b1);
                      chk1("valid_after_n1", data_out_valid, 1'b0);
      @(negedge clk); chk1("valid_after_n2", data_out_valid, 1'b1);
    end
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk); #1;
      done = (exp_q.size() == 0);
    end
    if (!done) chk1("replay_timeout", 1'b0, 1'b1);
    @(negedge clk); #1;
    chk1("playing_end", playing, 1'b0);
    chk1("valid_end", data_out_valid, 1'b0);
    chk1("ready_end", byte_in_ready, 1'b1);
    chkw("hs_count", W'(hs_count), W'(DEPTH));
    if (mode == 0) chkw("consecutive", W'(last_hs - first_hs), W'(DEPTH - 1));
    @(posedge clk); #1;
  endtask

  task automatic play_reset();
    bit hit = 1'b0;
    ready_mode = 0;
    hs_count   = 0;
    for (int w = 0; w < DEPTH; w++) exp_q.push_back(exp_mem[w]);
    @(posedge clk); #1;
    start_playback = 1'b1;
    @(posedge clk); #1;
    start_playback = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk); #1;
      hit = (exp_q.size() <= DEPTH - 7);
    end
    if (!hit) chk1("reset_point_timeout", 1'b0, 1'b1);
    arst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("rst_valid", data_out_valid, 1'b0);
    chk1("rst_playing", playing, 1'b0);
    chk1("rst_ready", byte_in_ready, 1'b1);
    chk1("rst_loaded", loaded, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    arst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1; byte_in = '0; byte_in_valid = 1'b0; start_playback = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk1("reset_ready", byte_in_ready, 1'b1);
    chk1("reset_loaded", loaded, 1'b0);
    chk1("reset_playing", playing, 1'b0);
    chk1("reset_valid", data_out_valid, 1'b0);
    chkw("reset_data", data_out, '0);
    @(posedge clk); #1;
    arst = 1'b0;

    load_all(1'b0, 1'b0, -1);
    play(0);
    chkw("first_word", first_word, 72'h080706050403020100);
    chkw("last_word", last_word, 72'h8F8E8D8C8B8A898887);

    load_all(1'b1, 1'b0, 50);
    play(1);

    load_all(1'b1, 1'b1, -1);
    play(1);

    load_all(1'b0, 1'b1, -1);
    play_reset();

    for (int i = 0; i < 13; i++) begin
      byte_in = 8'($urandom); byte_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    byte_in_valid = 1'b0;
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;

    load_all(1'b1, 1'b1, -1);
    play(1);
    load_all(1'b0, 1'b1, -1);
    play(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
